// File: rtl/nn_pkg.sv
// Shared definitions for the neuron-layer streaming blocks: the streamer FSM
// state encoding, the default activation width and an index-width helper.
package nn_pkg;

    // Default activation element width, kept in step with the layer default.
    localparam int NN_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Bits needed to index n elements. Never returns less than 1, so a
    // two-element vector still gets a real counter bit.
    function automatic int clog2_f(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/layer_streamer_if.sv
// Bundle of the parallel-capture inputs and the serial element stream.
// The master side drives the upstream layer / downstream ready; the slave
// side is the streamer itself.
interface layer_streamer_if #(
    parameter int NUM_NEURONS = 128,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 32
) ();
    logic [NUM_NEURONS-1:0]            out_valids;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] layer_in;
    logic                              ready;
    logic [DATA_WIDTH-1:0]             data_out;
    logic                              input_valid;
    logic [ADDR_WIDTH-1:0]             local_addr;
    logic                              last;
    logic                              layer_done;
    logic                              busy;
    logic                              overrun_err;
    logic                              partial_err;

    modport master (
        output out_valids, layer_in, ready,
        input  data_out, input_valid, local_addr, last, layer_done,
               busy, overrun_err, partial_err
    );

    modport slave (
        input  out_valids, layer_in, ready,
        output data_out, input_valid, local_addr, last, layer_done,
               busy, overrun_err, partial_err
    );
endinterface

// File: rtl/layer_stream_buf.sv
// Vector buffer: loads the whole activation vector in one cycle and offers
// an indexed combinational read of one element.
module layer_stream_buf #(
    parameter int NUM_NEURONS = 128,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_W       = 7
) (
    input  logic                              clk,
    input  logic                              wr_en_i,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] wr_data_i,
    input  logic [IDX_W-1:0]                  rd_idx_i,
    output logic [DATA_WIDTH-1:0]             rd_data_o
);

    // Contents are don't-care after reset, so no reset term is needed here.
    logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] mem_q;

    // Write-all port: the full vector is replaced on a capture.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q <= wr_data_i;
        end else begin
            mem_q <= mem_q;
        end
    end

    // Indexed read mux; the controller never presents an index past the end.
    always_comb begin
        rd_data_o = mem_q[rd_idx_i];
    end

endmodule

// File: rtl/layer_streamer.sv
// Captures a full parallel activation vector once every neuron is valid and
// replays it one element per cycle with valid/ready handshaking, an
// end-of-vector marker, a done pulse and sticky error flags.
module layer_streamer
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = 128,
    parameter int DATA_WIDTH  = NN_DATA_WIDTH,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst,
    layer_streamer_if.slave  bus
);

    localparam int                IDX_W    = clog2_f(NUM_NEURONS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    logic                    capture_s;
    logic                    partial_s;
    logic                    accept_s;
    logic                    load_s;
    logic                    ovr_hit_s;
    logic                    streaming_s;
    logic [DATA_WIDTH-1:0]   rd_data_s;

    logic [DATA_WIDTH-1:0]   data_out_q,    data_out_d;
    logic                    input_valid_q, input_valid_d;
    logic [ADDR_WIDTH-1:0]   local_addr_q,  local_addr_d;
    logic                    last_q,        last_d;
    logic                    layer_done_q,  layer_done_d;
    logic                    busy_q,        busy_d;
    logic                    overrun_q,     overrun_d;
    logic                    partial_q,     partial_d;

    layer_stream_buf #(
        .NUM_NEURONS (NUM_NEURONS),
        .DATA_WIDTH  (DATA_WIDTH),
        .IDX_W       (IDX_W)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (load_s),
        .wr_data_i (bus.layer_in),
        .rd_idx_i  (idx_d),
        .rd_data_o (rd_data_s)
    );

    // Decode the upstream strobes and the downstream handshake.
    always_comb begin
        capture_s = &bus.out_valids;
        partial_s = (|bus.out_valids) & ~capture_s;
        accept_s  = input_valid_q & bus.ready;
    end

    // Next-state logic: capture, index advance, end-of-vector and overrun.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        load_s       = 1'b0;
        ovr_hit_s    = 1'b0;
        layer_done_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (capture_s) begin
                    load_s  = 1'b1;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                // A capture while streaming is dropped, even on the final accept.
                if (capture_s) begin
                    ovr_hit_s = 1'b1;
                end else begin
                    ovr_hit_s = 1'b0;
                end
                if (accept_s) begin
                    if (idx_q == LAST_IDX) begin
                        state_d      = ST_DONE;
                        layer_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered-output next values, derived from the upcoming state/index.
    always_comb begin
        streaming_s   = (state_d == ST_STREAM);
        input_valid_d = streaming_s;
        busy_d        = streaming_s;
        overrun_d     = overrun_q | ovr_hit_s;
        partial_d     = partial_q | partial_s;
        if (!streaming_s) begin
            data_out_d = {DATA_WIDTH{1'b0}};
        end else if (load_s) begin
            // The buffer is written on this same edge, so bypass element 0.
            data_out_d = bus.layer_in[DATA_WIDTH-1:0];
        end else begin
            data_out_d = rd_data_s;
        end
        if (streaming_s) begin
            local_addr_d = ADDR_WIDTH'(idx_d);
            last_d       = (idx_d == LAST_IDX);
        end else begin
            local_addr_d = {ADDR_WIDTH{1'b0}};
            last_d       = 1'b0;
        end
    end

    // State, index and output registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= {IDX_W{1'b0}};
            data_out_q    <= {DATA_WIDTH{1'b0}};
            input_valid_q <= 1'b0;
            local_addr_q  <= {ADDR_WIDTH{1'b0}};
            last_q        <= 1'b0;
            layer_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            partial_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            data_out_q    <= data_out_d;
            input_valid_q <= input_valid_d;
            local_addr_q  <= local_addr_d;
            last_q        <= last_d;
            layer_done_q  <= layer_done_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            partial_q     <= partial_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.input_valid = input_valid_q;
    assign bus.local_addr  = local_addr_q;
    assign bus.last        = last_q;
    assign bus.layer_done  = layer_done_q;
    assign bus.busy        = busy_q;
    assign bus.overrun_err = overrun_q;
    assign bus.partial_err = partial_q;

endmodule

// File: tb/tb_layer_streamer.sv
// Scoreboard bench for layer_streamer (4 x 16-bit vector): directed scenarios
// followed by random capture/backpressure traffic, all checked against a
// transaction-level reference model.
module tb_layer_streamer;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    layer_streamer_if #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    layer_streamer #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a vector is either being delivered (pending elements
    // remain) or not. A full-valid strobe starts a new delivery only when
    // nothing is pending before the edge; otherwise it is an overrun.
    exp_t exp_q[$];
    int   m_pending = 0;
    logic m_done = 1'b0;
    logic m_ovr  = 1'b0;
    logic m_part = 1'b0;

    wire m_cap  = &bus.out_valids;
    wire m_prt  = (bus.out_valids != '0) && !m_cap;
    wire m_acc  = (m_pending > 0) && bus.ready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pending <= 0;
            m_done    <= 1'b0;
            m_ovr     <= 1'b0;
            m_part    <= 1'b0;
            exp_q.delete();
        end else begin
            m_done <= m_acc && (m_pending == 1);
            m_ovr  <= m_ovr | (m_cap && (m_pending != 0));
            m_part <= m_part | m_prt;
            if (m_cap && (m_pending == 0)) begin
                m_pending <= N;
                for (int i = 0; i < N; i++) begin
                    exp_q.push_back('{addr: AW'(i),
                                      data: bus.layer_in[i*DW +: DW],
                                      last: (i == N - 1)});
                end
            end else if (m_acc) begin
                m_pending <= m_pending - 1;
            end
        end
    end

    // Monitor: compares DUT status every cycle and pops one expected
    // element whenever an element is handed over.
    always @(negedge clk) begin
        if (!rst) begin
            chk("input_valid", bus.input_valid, m_pending > 0);
            chk("busy", bus.busy, m_pending > 0);
            chk("layer_done", bus.layer_done, m_done);
            chk("overrun_err", bus.overrun_err, m_ovr);
            chk("partial_err", bus.partial_err, m_part);
            if (!bus.input_valid) begin
                chk("last_idle", bus.last, 1'b0);
            end
            if (bus.input_valid && bus.ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_element", 1'b1, 1'b0);
                end else begin
                    chk("local_addr", bus.local_addr, exp_q[0].addr);
                    chk("data_out", bus.data_out, exp_q[0].data);
                    chk("last", bus.last, exp_q[0].last);
                    exp_q.pop_front();
                end
            end
        end
    end

    task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic r);
        bus.out_valids = v;
        bus.layer_in   = d;
        bus.ready      = r;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_out"}, bus.data_out, '0);
        chk({tag, "_input_valid"}, bus.input_valid, 1'b0);
        chk({tag, "_local_addr"}, bus.local_addr, '0);
        chk({tag, "_last"}, bus.last, 1'b0);
        chk({tag, "_layer_done"}, bus.layer_done, 1'b0);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_overrun"}, bus.overrun_err, 1'b0);
        chk({tag, "_partial"}, bus.partial_err, 1'b0);
    endtask

    function automatic logic [N*DW-1:0] rand_vec();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) begin
            v[i*DW +: DW] = DW'($urandom);
        end
        return v;
    endfunction

    localparam logic [N-1:0] ALL = {N{1'b1}};
    localparam logic [N-1:0] NONE = '0;

    initial begin
        logic [N*DW-1:0] v2;
        int r;
        bus.out_valids = '0;
        bus.layer_in   = '0;
        bus.ready      = 1'b0;

        // Reset state.
        #1 rst = 1'b1;
        #2 chk_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        // Basic stream with ready held high.
        step(ALL, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1'b1);
        for (int i = 0; i < 6; i++) step(NONE, '0, 1'b1);

        // Backpressure: ready low for three cycles while element 1 is shown.
        step(ALL, rand_vec(), 1'b1);
        step(NONE, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(NONE, '0, 1'b0);
        for (int i = 0; i < 6; i++) step(NONE, '0, 1'b1);

        // Back-to-back: second capture lands in the DONE cycle.
        step(ALL, rand_vec(), 1'b1);
        for (int i = 0; i < 4; i++) step(NONE, '0, 1'b1);
        v2 = rand_vec();
        step(ALL, v2, 1'b1);
        chk("b2b_first_addr", bus.local_addr, '0);
        chk("b2b_first_data", bus.data_out, v2[DW-1:0]);
        for (int i = 0; i < 6; i++) step(NONE, '0, 1'b1);
        chk("b2b_no_overrun", bus.overrun_err, 1'b0);

        // Partial valid while idle.
        step(4'b0101, rand_vec(), 1'b1);
        for (int i = 0; i < 3; i++) step(NONE, '0, 1'b1);

        // Overrun: new vector of 0xAAAA arrives while element 2 is shown.
        step(ALL, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 1'b1);
        step(NONE, '0, 1'b1);
        step(NONE, '0, 1'b1);
        step(ALL, {N{16'hAAAA}}, 1'b1);
        for (int i = 0; i < 8; i++) step(NONE, '0, 1'b1);

        // Asynchronous reset mid-stream at element 2.
        step(ALL, rand_vec(), 1'b1);
        step(NONE, '0, 1'b1);
        step(NONE, '0, 1'b1);
        #1 rst = 1'b1;
        #1 chk_all_zero("midrst");
        @(posedge clk);
        #1 chk("midrst_no_done", bus.layer_done, 1'b0);
        #1 rst = 1'b0;
        step(ALL, rand_vec(), 1'b1);
        chk("post_rst_addr", bus.local_addr, '0);
        for (int i = 0; i < 6; i++) step(NONE, '0, 1'b1);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 99);
            if (r < 12)      step(ALL, rand_vec(), ($urandom_range(0, 99) < 70));
            else if (r < 14) step(N'($urandom_range(1, 14)), rand_vec(), ($urandom_range(0, 99) < 70));
            else             step(NONE, rand_vec(), ($urandom_range(0, 99) < 70));
        end

        // Drain.
        for (int i = 0; i < 8; i++) step(NONE, '0, 1'b1);
        chk("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
